// File: rtl/splitter_pkg.sv
// Shared types and constants for the multi-channel transmission splitter.
package splitter_pkg;

    localparam int SPL_NUM_CH     = 4;
    localparam int SPL_ADDR_W     = 64;
    localparam int SPL_DEV_ADDR_W = 32;
    localparam int SPL_SIZE_W     = 32;
    localparam int SPL_MAX_CHUNK  = 256;
    localparam int SPL_BOUNDARY   = 4096;

    localparam int CH_W = (SPL_NUM_CH > 1) ? $clog2(SPL_NUM_CH) : 1;

    // Offset of a host address inside its no-cross window.
    localparam logic [SPL_ADDR_W-1:0] BOUNDARY_MASK = SPL_ADDR_W'(SPL_BOUNDARY - 1);

    typedef enum logic {
        ARB   = 1'b0,
        ISSUE = 1'b1
    } state_t;

    typedef struct packed {
        logic [SPL_ADDR_W-1:0]     host;
        logic [SPL_DEV_ADDR_W-1:0] dev;
        logic [SPL_SIZE_W-1:0]     size;
        logic                      dir;
        logic [CH_W-1:0]           channel;
    } chunk_t;

    function automatic logic [SPL_SIZE_W-1:0] min3(input logic [SPL_SIZE_W-1:0] a,
                                                   input logic [SPL_SIZE_W-1:0] b,
                                                   input logic [SPL_SIZE_W-1:0] c);
        logic [SPL_SIZE_W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/transmission_splitter_mc_if.sv
// Downstream chunk request interface towards the PCIe DMA engine.
interface transmission_splitter_mc_if #(
    parameter int ADDR_W     = splitter_pkg::SPL_ADDR_W,
    parameter int DEV_ADDR_W = splitter_pkg::SPL_DEV_ADDR_W,
    parameter int SIZE_W     = splitter_pkg::SPL_SIZE_W,
    parameter int CH_W       = splitter_pkg::CH_W
);
    logic                  dma_pending;
    logic                  dma_done;
    logic [SIZE_W-1:0]     dma_size;
    logic [ADDR_W-1:0]     dma_address_host;
    logic [DEV_ADDR_W-1:0] dma_address_device;
    logic                  dma_dir_write;
    logic [CH_W-1:0]       dma_channel;

    modport master (
        output dma_pending, dma_size, dma_address_host, dma_address_device,
               dma_dir_write, dma_channel,
        input  dma_done
    );

    modport slave (
        input  dma_pending, dma_size, dma_address_host, dma_address_device,
               dma_dir_write, dma_channel,
        output dma_done
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer.
module rr_arbiter
    import splitter_pkg::*;
#(
    parameter int NUM_CH  = SPL_NUM_CH,
    parameter int ARB_W   = CH_W
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [ARB_W-1:0]  ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [ARB_W-1:0]  idx_o
);
    logic             found;
    logic [ARB_W-1:0] cand;

    // scan NUM_CH positions starting from the pointer, wrapping around
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = ARB_W'((int'(ptr_i) + i) % NUM_CH);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end
endmodule

// File: rtl/transmission_splitter_mc.sv
// Multi-channel DMA descriptor splitter: cuts descriptors into boundary-safe
// chunks and round-robins them onto a single chunk request interface.
//   state | meaning
//   ARB   | pick next active channel, latch its chunk
//   ISSUE | chunk pending, waiting for dma_done
module transmission_splitter_mc
    import splitter_pkg::*;
#(
    parameter int NUM_CH     = SPL_NUM_CH,
    parameter int ADDR_W     = SPL_ADDR_W,
    parameter int DEV_ADDR_W = SPL_DEV_ADDR_W,
    parameter int SIZE_W     = SPL_SIZE_W,
    parameter int MAX_CHUNK  = SPL_MAX_CHUNK,
    parameter int BOUNDARY   = SPL_BOUNDARY
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_CH*ADDR_W-1:0]     conf_start_address_host,
    input  logic [NUM_CH*DEV_ADDR_W-1:0] conf_start_address_device,
    input  logic [NUM_CH*SIZE_W-1:0]     conf_size,
    input  logic [NUM_CH-1:0]            conf_dir_write,
    input  logic [NUM_CH-1:0]            conf_valid,
    output logic [NUM_CH-1:0]            conf_ready,
    output logic [NUM_CH-1:0]            conf_transaction_done,
    transmission_splitter_mc_if.master   dma
);
    localparam int LCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t                state_q;
    chunk_t                chunk_q;
    chunk_t                chunk_d;
    logic                  pending_q;
    logic [LCH_W-1:0]      rr_ptr_q;
    logic [ADDR_W-1:0]     cur_host_q [NUM_CH];
    logic [DEV_ADDR_W-1:0] cur_dev_q  [NUM_CH];
    logic [SIZE_W-1:0]     rem_q      [NUM_CH];
    logic [NUM_CH-1:0]     dir_q;
    logic [NUM_CH-1:0]     active_q;
    logic [NUM_CH-1:0]     ready_q;
    logic [NUM_CH-1:0]     done_q;
    logic [NUM_CH-1:0]     arb_gnt;
    logic [NUM_CH-1:0]     accept;
    logic [LCH_W-1:0]      arb_idx;
    logic [SIZE_W-1:0]     space_d;
    logic                  chunk_done;

    rr_arbiter #(.NUM_CH(NUM_CH), .ARB_W(LCH_W)) u_arb (
        .req_i (active_q),
        .ptr_i (rr_ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    assign accept     = conf_valid & ready_q;
    assign chunk_done = (state_q == ISSUE) && dma.dma_done;

    // chunk the arbitration winner would issue next
    always_comb begin
        space_d = SIZE_W'(BOUNDARY) - SIZE_W'(cur_host_q[arb_idx] & BOUNDARY_MASK);
        chunk_d = '{host:    cur_host_q[arb_idx],
                    dev:     cur_dev_q[arb_idx],
                    size:    min3(rem_q[arb_idx], SIZE_W'(MAX_CHUNK), space_d),
                    dir:     dir_q[arb_idx],
                    channel: arb_idx};
    end

    // top FSM with registered chunk request outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ARB;
            pending_q <= 1'b0;
            chunk_q   <= '0;
            rr_ptr_q  <= '0;
        end else begin
            case (state_q)
                ARB: begin
                    if (|arb_gnt) begin
                        chunk_q   <= chunk_d;
                        pending_q <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (dma.dma_done) begin
                        pending_q <= 1'b0;
                        rr_ptr_q  <= (chunk_q.channel == LCH_W'(NUM_CH - 1)) ? '0
                                     : chunk_q.channel + 1'b1;
                        state_q   <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    // per-channel descriptor contexts; ready returns the cycle after the done pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cur_host_q[c] <= '0;
                cur_dev_q[c]  <= '0;
                rem_q[c]      <= '0;
            end
            dir_q    <= '0;
            active_q <= '0;
            ready_q  <= '1;
            done_q   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (done_q[c]) begin
                    done_q[c]  <= 1'b0;
                    ready_q[c] <= 1'b1;
                end
                if (accept[c]) begin
                    cur_host_q[c] <= conf_start_address_host[c*ADDR_W +: ADDR_W];
                    cur_dev_q[c]  <= conf_start_address_device[c*DEV_ADDR_W +: DEV_ADDR_W];
                    rem_q[c]      <= conf_size[c*SIZE_W +: SIZE_W];
                    dir_q[c]      <= conf_dir_write[c];
                    ready_q[c]    <= 1'b0;
                    if (conf_size[c*SIZE_W +: SIZE_W] == '0) begin
                        done_q[c] <= 1'b1;
                    end else begin
                        active_q[c] <= 1'b1;
                    end
                end
                if (chunk_done && (chunk_q.channel == LCH_W'(c))) begin
                    cur_host_q[c] <= cur_host_q[c] + ADDR_W'(chunk_q.size);
                    cur_dev_q[c]  <= cur_dev_q[c] + DEV_ADDR_W'(chunk_q.size);
                    rem_q[c]      <= rem_q[c] - chunk_q.size;
                    if (rem_q[c] == chunk_q.size) begin
                        active_q[c] <= 1'b0;
                        done_q[c]   <= 1'b1;
                    end
                end
            end
        end
    end

    assign conf_ready             = ready_q;
    assign conf_transaction_done  = done_q;
    assign dma.dma_pending        = pending_q;
    assign dma.dma_size           = chunk_q.size;
    assign dma.dma_address_host   = chunk_q.host;
    assign dma.dma_address_device = chunk_q.dev;
    assign dma.dma_dir_write      = chunk_q.dir;
    assign dma.dma_channel        = chunk_q.channel;

endmodule

// File: tb/tb_transmission_splitter_mc.sv
// Bench for transmission_splitter_mc: acts as the DMA engine and host config.
module tb_transmission_splitter_mc;
    import splitter_pkg::*;

    localparam int NCH = 4;
    localparam int AW  = 64;
    localparam int DW  = 32;
    localparam int SW  = 32;

    logic                i_clk;
    logic                i_rst_n;
    logic [NCH*AW-1:0]   conf_start_address_host;
    logic [NCH*DW-1:0]   conf_start_address_device;
    logic [NCH*SW-1:0]   conf_size;
    logic [NCH-1:0]      conf_dir_write;
    logic [NCH-1:0]      conf_valid;
    logic [NCH-1:0]      conf_ready;
    logic [NCH-1:0]      conf_transaction_done;

    transmission_splitter_mc_if dma_if ();

    transmission_splitter_mc dut (
        .i_clk                     (i_clk),
        .i_rst_n                   (i_rst_n),
        .conf_start_address_host   (conf_start_address_host),
        .conf_start_address_device (conf_start_address_device),
        .conf_size                 (conf_size),
        .conf_dir_write            (conf_dir_write),
        .conf_valid                (conf_valid),
        .conf_ready                (conf_ready),
        .conf_transaction_done     (conf_transaction_done),
        .dma                       (dma_if)
    );

    int n_tests;
    int n_fail;
    int done_cnt [NCH];

    typedef struct {
        logic [63:0] host;
        logic [31:0] dev;
        logic [31:0] size;
        int          n;
        logic [31:0] first_sz;
        logic [31:0] last_sz;
        logic [63:0] last_host;
        logic [31:0] last_dev;
    } vec_t;

    vec_t vecs [6];

    // reference chunk lists per channel
    logic [63:0] m_host [NCH][24];
    logic [31:0] m_dev  [NCH][24];
    logic [31:0] m_size [NCH][24];
    logic        m_dir  [NCH];
    int          m_n    [NCH];
    int          m_hd   [NCH];
    int          m_ptr;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
        for (int c = 0; c < NCH; c++)
            if (conf_transaction_done[c]) done_cnt[c]++;
    endtask

    task automatic set_desc(input int c, input logic [63:0] h, input logic [31:0] d,
                            input logic [31:0] s, input logic dir);
        conf_start_address_host[c*AW +: AW]   = h;
        conf_start_address_device[c*DW +: DW] = d;
        conf_size[c*SW +: SW]                 = s;
        conf_dir_write[c]                     = dir;
    endtask

    task automatic wait_pending(output bit ok);
        int k;
        k  = 0;
        ok = dma_if.dma_pending;
        while (!ok && k < 40) begin
            step();
            k++;
            ok = dma_if.dma_pending;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL pending_timeout: got 0 expected 1");
        end
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
        step();
    endtask

    // expected chunk list from plain arithmetic on the splitting rules
    task automatic model_load(input int c, input logic [63:0] h, input logic [31:0] d,
                              input logic [31:0] s, input logic dir);
        logic [63:0] hh;
        logic [63:0] r;
        logic [63:0] sz;
        logic [31:0] dd;
        hh = h; dd = d; r = 64'(s);
        m_n[c] = 0; m_hd[c] = 0; m_dir[c] = dir;
        while (r != 0) begin
            sz = r;
            if (sz > 64'd256) sz = 64'd256;
            if (sz > 64'd4096 - (hh % 64'd4096)) sz = 64'd4096 - (hh % 64'd4096);
            m_host[c][m_n[c]] = hh;
            m_dev[c][m_n[c]]  = dd;
            m_size[c][m_n[c]] = sz[31:0];
            m_n[c]++;
            hh = hh + sz;
            dd = dd + sz[31:0];
            r  = r - sz;
        end
    endtask

    task automatic run_vec(input int i);
        bit          ok;
        bit          fin;
        int          n;
        int          base;
        logic        dir;
        logic [31:0] last_sz;
        logic [63:0] last_host;
        logic [31:0] last_dev;
        dir = 1'(i % 2);
        set_desc(0, vecs[i].host, vecs[i].dev, vecs[i].size, dir);
        base = done_cnt[0];
        conf_valid[0] = 1'b1;
        step();
        check($sformatf("v%0d_ready_low", i), 64'(conf_ready[0]), 64'd0);
        conf_valid[0] = 1'b0;
        check($sformatf("v%0d_pending_n1", i), 64'(dma_if.dma_pending), 64'd0);
        step();
        check($sformatf("v%0d_pending_n2", i), 64'(dma_if.dma_pending), 64'd1);
        n = 0; fin = 0; last_sz = '0; last_host = '0; last_dev = '0;
        while (!fin && n < 12) begin
            wait_pending(ok);
            if (!ok) break;
            if (n == 0)
                check($sformatf("v%0d_first_size", i), 64'(dma_if.dma_size), 64'(vecs[i].first_sz));
            check($sformatf("v%0d_dir", i), 64'(dma_if.dma_dir_write), 64'(dir));
            last_sz   = dma_if.dma_size;
            last_host = dma_if.dma_address_host;
            last_dev  = dma_if.dma_address_device;
            n++;
            dma_if.dma_done = 1'b1;
            step();
            dma_if.dma_done = 1'b0;
            check($sformatf("v%0d_pending_drop", i), 64'(dma_if.dma_pending), 64'd0);
            if (conf_transaction_done[0]) begin
                fin = 1;
                check($sformatf("v%0d_ready_at_pulse", i), 64'(conf_ready[0]), 64'd0);
            end else begin
                step();
                check($sformatf("v%0d_b2b_gap", i), 64'(dma_if.dma_pending), 64'd1);
            end
        end
        check($sformatf("v%0d_nchunks", i), 64'(n), 64'(vecs[i].n));
        check($sformatf("v%0d_last_size", i), 64'(last_sz), 64'(vecs[i].last_sz));
        check($sformatf("v%0d_last_host", i), last_host, vecs[i].last_host);
        check($sformatf("v%0d_last_dev", i), 64'(last_dev), 64'(vecs[i].last_dev));
        step();
        check($sformatf("v%0d_ready_back", i), 64'(conf_ready[0]), 64'd1);
        check($sformatf("v%0d_done_count", i), 64'(done_cnt[0] - base), 64'd1);
    endtask

    initial begin
        bit ok;
        int seq [4];
        int exp_seq [4];
        int d0k, d1k, base, total, j;
        int base_r [NCH];
        logic [63:0] h;
        logic [31:0] s;

        vecs[0] = '{64'h1000, 32'h0, 32'h300, 3, 32'h100, 32'h100, 64'h1200, 32'h200};
        vecs[1] = '{64'h0FF0, 32'h0, 32'h40, 2, 32'h10, 32'h30, 64'h1000, 32'h10};
        vecs[2] = '{64'h0, 32'h55, 32'h1, 1, 32'h1, 32'h1, 64'h0, 32'h55};
        vecs[3] = '{64'h0FFF, 32'hFFFF_FFFF, 32'h2, 2, 32'h1, 32'h1, 64'h1000, 32'h0};
        vecs[4] = '{64'h0F80, 32'h100, 32'h200, 3, 32'h80, 32'h80, 64'h1100, 32'h280};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FF00, 32'h10, 32'h200, 2, 32'h100, 32'h100, 64'h0, 32'h110};
        exp_seq = '{0, 1, 0, 1};

        n_tests = 0; n_fail = 0;
        for (int c = 0; c < NCH; c++) done_cnt[c] = 0;
        i_rst_n = 1'b0;
        conf_start_address_host = '0; conf_start_address_device = '0;
        conf_size = '0; conf_dir_write = '0; conf_valid = '0;
        dma_if.dma_done = 1'b0;
        step();
        check("rst_pending", 64'(dma_if.dma_pending), 64'd0);
        check("rst_ready", 64'(conf_ready), 64'hF);
        check("rst_done", 64'(conf_transaction_done), 64'd0);
        check("rst_size", 64'(dma_if.dma_size), 64'd0);
        check("rst_host", dma_if.dma_address_host, 64'd0);
        check("rst_channel", 64'(dma_if.dma_channel), 64'd0);
        i_rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vec(i);

        // two channels accepted together alternate chunk by chunk
        do_reset();
        set_desc(0, 64'h0, 32'h0, 32'h200, 1'b0);
        set_desc(1, 64'h2000, 32'h800, 32'h200, 1'b1);
        conf_valid = 4'b0011;
        step();
        conf_valid = '0;
        d0k = -1; d1k = -1;
        for (int k = 0; k < 4; k++) begin
            wait_pending(ok);
            seq[k] = int'(dma_if.dma_channel);
            dma_if.dma_done = 1'b1;
            step();
            dma_if.dma_done = 1'b0;
            if (conf_transaction_done[0] && d0k < 0) d0k = k;
            if (conf_transaction_done[1] && d1k < 0) d1k = k;
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("rr_seq%0d", k), 64'(seq[k]), 64'(exp_seq[k]));
        check("rr_done0_at", 64'(d0k), 64'd2);
        check("rr_done1_at", 64'(d1k), 64'd3);
        step();

        // zero-size descriptor completes without a chunk
        set_desc(2, 64'h3000, 32'h0, 32'h0, 1'b0);
        conf_valid[2] = 1'b1;
        step();
        conf_valid[2] = 1'b0;
        check("zero_done_n1", 64'(conf_transaction_done[2]), 64'd1);
        check("zero_ready_n1", 64'(conf_ready[2]), 64'd0);
        check("zero_pending_n1", 64'(dma_if.dma_pending), 64'd0);
        step();
        check("zero_done_n2", 64'(conf_transaction_done[2]), 64'd0);
        check("zero_ready_n2", 64'(conf_ready[2]), 64'd1);
        step();
        check("zero_pending_n3", 64'(dma_if.dma_pending), 64'd0);

        // reset while a chunk is pending
        set_desc(0, 64'h0, 32'h0, 32'h100, 1'b0);
        conf_valid[0] = 1'b1;
        step();
        conf_valid[0] = 1'b0;
        wait_pending(ok);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("midrst_pending", 64'(dma_if.dma_pending), 64'd0);
        check("midrst_ready", 64'(conf_ready), 64'hF);
        base = done_cnt[0];
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check("midrst_no_done", 64'(done_cnt[0] - base), 64'd0);
        check("midrst_idle", 64'(dma_if.dma_pending), 64'd0);

        // busy channel holds valid, stray done in ARB is ignored
        set_desc(0, 64'h0, 32'h0, 32'h200, 1'b0);
        conf_valid[0] = 1'b1;
        step();
        set_desc(0, 64'h5000, 32'h40, 32'h40, 1'b1);
        check("busy_ready_low", 64'(conf_ready[0]), 64'd0);
        wait_pending(ok);
        check("busy_c1_host", dma_if.dma_address_host, 64'h0);
        dma_if.dma_done = 1'b1;
        step();
        dma_if.dma_done = 1'b1;
        step();
        dma_if.dma_done = 1'b0;
        check("stray_pending", 64'(dma_if.dma_pending), 64'd1);
        check("stray_host", dma_if.dma_address_host, 64'h100);
        check("stray_size", 64'(dma_if.dma_size), 64'h100);
        dma_if.dma_done = 1'b1;
        step();
        dma_if.dma_done = 1'b0;
        check("busy_done", 64'(conf_transaction_done[0]), 64'd1);
        check("busy_ready_pulse", 64'(conf_ready[0]), 64'd0);
        step();
        check("busy_ready_back", 64'(conf_ready[0]), 64'd1);
        step();
        check("busy_reaccept", 64'(conf_ready[0]), 64'd0);
        conf_valid[0] = 1'b0;
        wait_pending(ok);
        check("new_host", dma_if.dma_address_host, 64'h5000);
        check("new_size", 64'(dma_if.dma_size), 64'h40);
        check("new_dev", 64'(dma_if.dma_address_device), 64'h40);
        dma_if.dma_done = 1'b1;
        step();
        dma_if.dma_done = 1'b0;
        check("new_done", 64'(conf_transaction_done[0]), 64'd1);
        step();

        // randomized descriptor sets against the reference model
        do_reset();
        m_ptr = 0;
        for (int r = 0; r < 25; r++) begin
            for (int c = 0; c < NCH; c++) begin
                h = {$urandom(), $urandom()};
                if ($urandom_range(0, 1) == 1) h[11:8] = 4'hF;
                s = ($urandom_range(0, 6) == 0) ? 32'h0 : 32'($urandom_range(1, 32'h500));
                set_desc(c, h, $urandom(), s, 1'($urandom_range(0, 1)));
                model_load(c, h, conf_start_address_device[c*DW +: DW], s, conf_dir_write[c]);
                base_r[c] = done_cnt[c];
            end
            conf_valid = '1;
            step();
            conf_valid = '0;
            total = 0;
            for (int c = 0; c < NCH; c++) total += m_n[c];
            for (int k = 0; k < total; k++) begin
                j = -1;
                for (int i = 0; i < NCH; i++)
                    if (j < 0 && m_hd[(m_ptr + i) % NCH] < m_n[(m_ptr + i) % NCH])
                        j = (m_ptr + i) % NCH;
                wait_pending(ok);
                if (!ok) break;
                check($sformatf("r%0d_k%0d_chan", r, k), 64'(dma_if.dma_channel), 64'(j));
                check($sformatf("r%0d_k%0d_host", r, k), dma_if.dma_address_host, m_host[j][m_hd[j]]);
                check($sformatf("r%0d_k%0d_dev", r, k), 64'(dma_if.dma_address_device), 64'(m_dev[j][m_hd[j]]));
                check($sformatf("r%0d_k%0d_size", r, k), 64'(dma_if.dma_size), 64'(m_size[j][m_hd[j]]));
                check($sformatf("r%0d_k%0d_dir", r, k), 64'(dma_if.dma_dir_write), 64'(m_dir[j]));
                for (int w = $urandom_range(0, 2); w > 0; w--) step();
                dma_if.dma_done = 1'b1;
                step();
                dma_if.dma_done = 1'b0;
                m_hd[j]++;
                m_ptr = (j + 1) % NCH;
                check($sformatf("r%0d_k%0d_donepulse", r, k), 64'(conf_transaction_done[j]),
                      (m_hd[j] == m_n[j]) ? 64'd1 : 64'd0);
            end
            step();
            step();
            for (int c = 0; c < NCH; c++)
                check($sformatf("r%0d_ch%0d_done_once", r, c), 64'(done_cnt[c] - base_r[c]), 64'd1);
            check($sformatf("r%0d_all_ready", r), 64'(conf_ready), 64'hF);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
